rv32_wb_master_bridge: RTL and testbench

//   Downstream neighbour of the core's memory stage. Converts the core's single-cycle

---
 rtl/rv32_bus_pkg.sv | 18 +
 rtl/rv32_wb_watchdog.sv | 29 ++
 rtl/rv32_wb_master_bridge.sv | 125 ++++++++++++
 tb/tb_rv32_wb_master_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bus_pkg.sv
// Shared bus types for the RV32 peripheral bridge.
// Holds the Wishbone master FSM states and the read byte-select constant.
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_BUS,
        WB_RESP
    } wb_state_t;

    localparam logic [3:0] WB_SEL_WORD = 4'hF;

    // Reads fetch the whole word; writes use the core's enables as-is.
    function automatic logic [3:0] wb_sel(input logic [3:0] we);
        return (we == 4'b0000) ? WB_SEL_WORD : we;
    endfunction

endpackage

// File: rtl/rv32_wb_watchdog.sv
// Bus-cycle watchdog: counts cycles spent waiting on the slave.
// Raises expired_o on the last allowed cycle so the master can give up.
module rv32_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Restart on each new bus cycle, saturate at the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count <= '0;
        end else if (run_i && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired_o = run_i && (count == LIMIT);

endmodule

// File: rtl/rv32_wb_master_bridge.sv
// Core peripheral access -> Wishbone B4 classic master cycle.
// Optional bus timeout is enabled by defining RV32_WB_TIMEOUT_EN.
module rv32_wb_master_bridge
    import rv32_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic [3:0]        core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_stall_o,
    output logic [31:0]       core_rdata_o,
    output logic              core_valid_o,
    output logic              core_err_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    wb_state_t   state;
    wb_state_t   state_nxt;
    logic        err_flag;
    logic [31:0] rdata_q;
    logic        accept;
    logic        timeout;

    assign accept = (state == WB_IDLE) && core_req_i;

`ifdef RV32_WB_TIMEOUT_EN
    rv32_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (accept),
        .run_i    (state == WB_BUS),
        .expired_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt    = state;
        core_stall_o = 1'b0;
        core_valid_o = 1'b0;
        core_err_o   = 1'b0;
        wb_cyc_o     = 1'b0;
        unique case (state)
            WB_IDLE: begin
                core_stall_o = core_req_i;
                if (core_req_i) begin
                    state_nxt = WB_BUS;
                end
            end
            WB_BUS: begin
                wb_cyc_o     = 1'b1;
                core_stall_o = 1'b1;
                if (wb_err_i || wb_ack_i || timeout) begin
                    state_nxt = WB_RESP;
                end
            end
            WB_RESP: begin
                core_valid_o = 1'b1;
                core_err_o   = err_flag;
                state_nxt    = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    assign wb_stb_o     = wb_cyc_o;
    assign core_rdata_o = rdata_q;

    // Latch the request on accept, capture the response on completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            rdata_q  <= '0;
            err_flag <= 1'b0;
        end else if (accept) begin
            wb_adr_o <= core_addr_i;
            wb_dat_o <= core_wdata_i;
            wb_sel_o <= wb_sel(core_we_i);
            wb_we_o  <= |core_we_i;
            err_flag <= 1'b0;
        end else if (state == WB_BUS) begin
            if (wb_err_i || timeout) begin
                rdata_q  <= '0;
                err_flag <= 1'b1;
            end else if (wb_ack_i) begin
                rdata_q  <= wb_dat_i;
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32_wb_master_bridge.sv
// Directed bench for rv32_wb_master_bridge.
// Table-driven accesses plus reset, back-to-back and timeout sequences.
module tb_rv32_wb_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        valid;
    logic        err;
    logic        cyc;
    logic        stb;
    logic        wb_we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        wb_err;

    int checks = 0;
    int errors = 0;
    int cyc_starts = 0;
    logic cyc_prev = 1'b0;

    always #5 clk = ~clk;

    rv32_wb_master_bridge #(
        .TIMEOUT_CYCLES(8),
        .ADDR_W(32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .core_req_i  (req),
        .core_we_i   (we),
        .core_addr_i (addr),
        .core_wdata_i(wdata),
        .core_stall_o(stall),
        .core_rdata_o(rdata),
        .core_valid_o(valid),
        .core_err_o  (err),
        .wb_cyc_o    (cyc),
        .wb_stb_o    (stb),
        .wb_we_o     (wb_we),
        .wb_sel_o    (sel),
        .wb_adr_o    (adr),
        .wb_dat_o    (dat_o),
        .wb_dat_i    (dat_i),
        .wb_ack_i    (ack),
        .wb_err_i    (wb_err)
    );

    always @(negedge clk) begin
        if (cyc && !cyc_prev) cyc_starts++;
        cyc_prev = cyc;
    end

    typedef struct {
        string       name;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] slave_dat;
        int          waits;
        logic        ack;
        logic        err;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        #1;
        chk({v.name, " stall_req"}, 32'(stall), 32'd1);
        chk({v.name, " cyc_req"}, 32'(cyc), 32'd0);
        @(negedge clk);
        for (int i = 0; i <= v.waits; i++) begin
            chk({v.name, " cyc"}, 32'(cyc), 32'd1);
            chk({v.name, " stb"}, 32'(stb), 32'd1);
            chk({v.name, " stall_bus"}, 32'(stall), 32'd1);
            chk({v.name, " valid_bus"}, 32'(valid), 32'd0);
            chk({v.name, " adr"}, adr, v.addr);
            chk({v.name, " sel"}, 32'(sel), 32'(v.exp_sel));
            chk({v.name, " we"}, 32'(wb_we), 32'(v.exp_we));
            chk({v.name, " dat_o"}, dat_o, v.wdata);
            if (i == v.waits) begin
                ack = v.ack; wb_err = v.err; dat_i = v.slave_dat;
            end
            @(negedge clk);
        end
        ack = 1'b0; wb_err = 1'b0;
        chk({v.name, " valid"}, 32'(valid), 32'd1);
        chk({v.name, " err"}, 32'(err), 32'(v.exp_err));
        chk({v.name, " rdata"}, rdata, v.exp_rdata);
        chk({v.name, " stall_resp"}, 32'(stall), 32'd0);
        chk({v.name, " cyc_resp"}, 32'(cyc), 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk({v.name, " valid_after"}, 32'(valid), 32'd0);
        chk({v.name, " no_reissue"}, 32'(cyc), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"rd_wait2", 4'b0000, 32'h2000_0004, 32'h0,
                    32'hA5A5_5A5A, 2, 1'b1, 1'b0,
                    4'hF, 1'b0, 32'hA5A5_5A5A, 1'b0};
        vecs[1] = '{"wr_byte", 4'b0010, 32'h2001_0000, 32'h0000_AB00,
                    32'h0, 0, 1'b1, 1'b0,
                    4'b0010, 1'b1, 32'h0, 1'b0};
        vecs[2] = '{"rd_ackerr", 4'b0000, 32'h2000_0008, 32'h0,
                    32'hDEAD_BEEF, 1, 1'b1, 1'b1,
                    4'hF, 1'b0, 32'h0, 1'b1};
        vecs[3] = '{"wr_err", 4'b1111, 32'h2000_0010, 32'h1234_5678,
                    32'h5555_5555, 0, 1'b0, 1'b1,
                    4'hF, 1'b1, 32'h0, 1'b1};
        vecs[4] = '{"wr_half", 4'b1100, 32'h2000_0014, 32'hCAFE_0000,
                    32'h0000_0077, 3, 1'b1, 1'b0,
                    4'b1100, 1'b1, 32'h0000_0077, 1'b0};

        rst = 1'b1; req = 1'b0; we = '0; addr = '0; wdata = '0;
        dat_i = '0; ack = 1'b0; wb_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst cyc", 32'(cyc), 32'd0);
        chk("rst stb", 32'(stb), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst sel", 32'(sel), 32'd0);
        chk("rst adr", adr, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset while the bus cycle is open.
        @(negedge clk);
        req = 1'b1; we = 4'b0000; addr = 32'h2000_0100;
        @(negedge clk);
        chk("midrst cyc_before", 32'(cyc), 32'd1);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("midrst cyc", 32'(cyc), 32'd0);
        chk("midrst stb", 32'(stb), 32'd0);
        chk("midrst rdata", rdata, 32'd0);
        rst = 1'b0; ack = 1'b1; dat_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst late_ack_valid", 32'(valid), 32'd0);
            chk("midrst late_ack_cyc", 32'(cyc), 32'd0);
        end
        ack = 1'b0;

        // Back-to-back read then write with req held high.
        begin
            int base;
            base = cyc_starts;
            @(negedge clk);
            req = 1'b1; we = 4'b0000; addr = 32'h2000_0020;
            @(negedge clk);
            ack = 1'b1; dat_i = 32'h1111_2222;
            @(negedge clk);
            ack = 1'b0;
            chk("b2b rd_valid", 32'(valid), 32'd1);
            chk("b2b rd_rdata", rdata, 32'h1111_2222);
            we = 4'b1111; addr = 32'h2000_0024; wdata = 32'h3333_4444;
            @(negedge clk);
            chk("b2b gap_cyc", 32'(cyc), 32'd0);
            chk("b2b gap_stall", 32'(stall), 32'd1);
            @(negedge clk);
            chk("b2b wr_cyc", 32'(cyc), 32'd1);
            chk("b2b wr_adr", adr, 32'h2000_0024);
            chk("b2b wr_we", 32'(wb_we), 32'd1);
            chk("b2b wr_dat", dat_o, 32'h3333_4444);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("b2b wr_valid", 32'(valid), 32'd1);
            req = 1'b0;
            @(negedge clk);
            chk("b2b idle_cyc", 32'(cyc), 32'd0);
            chk("b2b cycles", 32'(cyc_starts - base), 32'd2);
        end

        // Slave that never answers.
        @(negedge clk);
        req = 1'b1; we = 4'b0000; addr = 32'h2000_0200;
        @(negedge clk);
`ifdef RV32_WB_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (cyc && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("tmo bus_cycles", 32'(n), 32'd8);
            chk("tmo valid", 32'(valid), 32'd1);
            chk("tmo err", 32'(err), 32'd1);
            chk("tmo rdata", rdata, 32'd0);
            req = 1'b0;
            @(negedge clk);
            chk("tmo valid_after", 32'(valid), 32'd0);
        end
`else
        begin
            int low;
            low = 0;
            for (int i = 0; i < 120; i++) begin
                if (!stall || !cyc || valid) low++;
                @(negedge clk);
            end
            chk("hang stall_drops", 32'(low), 32'd0);
            chk("hang cyc", 32'(cyc), 32'd1);
            rst = 1'b1; req = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk("hang recover_cyc", 32'(cyc), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
